// File: rtl/coeff_pkg.sv
// Shared definitions for the coefficient streamer: FSM encoding,
// derived-width helpers and the saturating negate used by the fold option.
package coeff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } coeff_state_t;

  // Index width for n entries, never below one bit.
  function automatic int width_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Stored taps per bank when symmetric folding is used.
  function automatic int half_len(input int len);
    return (len + 1) / 2;
  endfunction

  // Negate a width-bit value (sign-extended to 64 bits); the most-negative
  // code has no positive twin, so it clips to the most-positive one.
  function automatic logic signed [63:0] sat_negate(input logic signed [63:0] v,
                                                    input int width);
    logic signed [63:0] lo;
    logic signed [63:0] hi;
    lo = -(64'sd1 <<< (width - 1));
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    if (v == lo) return hi;
    return -v;
  endfunction

endpackage

// File: rtl/coeff_bank_ram.sv
// Coefficient storage: NUM_BANKS x DEPTH words, one synchronous write port
// and one combinational read port. The parent registers the read data, so a
// write and a read of the same word in one cycle delivers the old contents.
module coeff_bank_ram #(
  parameter int NUM_BANKS  = 4,
  parameter int DEPTH      = 27,
  parameter int DATA_WIDTH = 18,
  parameter int BANK_BITS  = 2,
  parameter int ADDR_BITS  = 5
) (
  input  logic                         clock,
  input  logic                         wr_en,
  input  logic [BANK_BITS-1:0]         wr_bank,
  input  logic [ADDR_BITS-1:0]         wr_addr,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  input  logic [BANK_BITS-1:0]         rd_bank,
  input  logic [ADDR_BITS-1:0]         rd_addr,
  output logic signed [DATA_WIDTH-1:0] rd_data
);

  // Contents are deliberately outside the reset domain; they survive reset.
  logic signed [DATA_WIDTH-1:0] mem [NUM_BANKS][DEPTH];

  // Host write port.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_bank][wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/setup_coeff_bank.sv
// Run-time loadable FIR coefficient streamer. Holds NUM_BANKS sets of LENGTH
// taps and, on enable, shifts the selected set out one tap per clock, then
// raises coeffSetFlag until enable drops.
// Build option: define SETUP_COEFF_FOLD_EN to store only (LENGTH+1)/2 taps
// per bank and mirror the rest, negated (saturating) for banks whose
// ANTISYM_MASK bit is set.
//
// state     | meaning
// ----------+----------------------------------------------
// ST_IDLE   | waiting for enable with a legal bankSelect
// ST_STREAM | delivering taps 1..LENGTH-1 of activeBank
// ST_DONE   | all taps delivered, flag held until enable=0
module setup_coeff_bank
  import coeff_pkg::*;
#(
  parameter int LENGTH       = 27,
  parameter int DATA_WIDTH   = 18,
  parameter int NUM_BANKS    = 4,
  parameter int ANTISYM_MASK = 1,
  localparam int BANK_BITS   = width_min1(NUM_BANKS),
  localparam int ADDR_BITS   = width_min1(LENGTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [BANK_BITS-1:0]         bankSelect,
  input  logic                         wrEnable,
  input  logic [BANK_BITS-1:0]         wrBank,
  input  logic [ADDR_BITS-1:0]         wrAddr,
  input  logic signed [DATA_WIDTH-1:0] wrData,
  output logic signed [DATA_WIDTH-1:0] coefficientOut,
  output logic                         coeffValid,
  output logic                         coeffSetFlag,
  output logic                         busy,
  output logic                         error
);

  localparam int CNT_BITS = ADDR_BITS + 1;
`ifdef SETUP_COEFF_FOLD_EN
  localparam int DEPTH = half_len(LENGTH);
  localparam logic [31:0] ANTI_BITS = 32'(ANTISYM_MASK);
`else
  localparam int DEPTH = LENGTH;
`endif
  localparam int RAM_ADDR_BITS = width_min1(DEPTH);

  coeff_state_t                 state, state_nxt;
  logic [CNT_BITS-1:0]          cnt, cnt_nxt;
  logic [BANK_BITS-1:0]         active_bank, bank_nxt;
  logic signed [DATA_WIDTH-1:0] out_nxt;
  logic                         valid_nxt, flag_nxt, busy_nxt, err_nxt;
  logic                         start_err;
  logic                         sel_ok, wr_legal, ram_wr_en;
  logic [BANK_BITS-1:0]         rd_bank;
  logic [CNT_BITS-1:0]          tap_idx;
  logic [RAM_ADDR_BITS-1:0]     rd_addr;
  logic signed [DATA_WIDTH-1:0] rd_data, tap_data;

  assign sel_ok   = 32'(bankSelect) < NUM_BANKS;
  // The streaming bank is locked against writes only while taps are flowing.
  assign wr_legal = (32'(wrBank) < NUM_BANKS) && (32'(wrAddr) < DEPTH) &&
                    !(busy && (wrBank == active_bank));
  assign ram_wr_en = wrEnable && wr_legal && !reset;

  coeff_bank_ram #(
    .NUM_BANKS  (NUM_BANKS),
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BANK_BITS  (BANK_BITS),
    .ADDR_BITS  (RAM_ADDR_BITS)
  ) u_ram (
    .clock   (clock),
    .wr_en   (ram_wr_en),
    .wr_bank (wrBank),
    .wr_addr (RAM_ADDR_BITS'(wrAddr)),
    .wr_data (wrData),
    .rd_bank (rd_bank),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Read address: tap 0 of the requested bank while idle, else the tap counter.
  always_comb begin
    rd_bank  = (state == ST_IDLE) ? bankSelect : active_bank;
    tap_idx  = (state == ST_IDLE) ? '0 : cnt;
    rd_addr  = RAM_ADDR_BITS'(tap_idx);
    tap_data = rd_data;
`ifdef SETUP_COEFF_FOLD_EN
    if (32'(tap_idx) >= DEPTH) begin
      rd_addr = RAM_ADDR_BITS'(CNT_BITS'(LENGTH - 1) - tap_idx);
      if (ANTI_BITS[rd_bank])
        tap_data = DATA_WIDTH'(sat_negate(64'(rd_data), DATA_WIDTH));
    end
`endif
  end

  // Next-state and next-output decode; everything idles unless a case drives it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bank_nxt  = active_bank;
    out_nxt   = '0;
    valid_nxt = 1'b0;
    flag_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    start_err = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (enable) begin
          if (sel_ok) begin
            bank_nxt  = bankSelect;
            out_nxt   = tap_data;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
            cnt_nxt   = CNT_BITS'(1);
            if (LENGTH == 1) begin
              flag_nxt  = 1'b1;
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_STREAM;
            end
          end else begin
            start_err = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          out_nxt   = tap_data;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          cnt_nxt   = cnt + CNT_BITS'(1);
          if (32'(cnt) == LENGTH - 1) begin
            flag_nxt  = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          flag_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    err_nxt = (wrEnable && !wr_legal) || start_err;
  end

  // State and registered outputs; reset overrides every other input.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      active_bank    <= '0;
      coefficientOut <= '0;
      coeffValid     <= 1'b0;
      coeffSetFlag   <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      active_bank    <= bank_nxt;
      coefficientOut <= out_nxt;
      coeffValid     <= valid_nxt;
      coeffSetFlag   <= flag_nxt;
      busy           <= busy_nxt;
      error          <= err_nxt;
    end
  end

endmodule

// File: tb/tb_setup_coeff_bank.sv
// Directed bench for setup_coeff_bank with default parameters
// (LENGTH=27, DATA_WIDTH=18, NUM_BANKS=4, ANTISYM_MASK=1).
// With SETUP_COEFF_FOLD_EN defined, only the reset and fold scenarios run.
module tb_setup_coeff_bank;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               enable = 1'b0;
  logic [1:0]         bankSelect = '0;
  logic               wrEnable = 1'b0;
  logic [1:0]         wrBank = '0;
  logic [4:0]         wrAddr = '0;
  logic signed [17:0] wrData = '0;
  logic signed [17:0] coefficientOut;
  logic               coeffValid, coeffSetFlag, busy, error;

  int n_checks = 0;
  int n_fail   = 0;

  int hil [27] = '{-775, 0, -1582, 0, -2850, 0, -4800, 0, -7920, 0, -13900, 0,
                   -41700, 0, 41700, 0, 13900, 0, 7920, 0, 4800, 0, 2850, 0,
                   1582, 0, 775};

  setup_coeff_bank dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .bankSelect     (bankSelect),
    .wrEnable       (wrEnable),
    .wrBank         (wrBank),
    .wrAddr         (wrAddr),
    .wrData         (wrData),
    .coefficientOut (coefficientOut),
    .coeffValid     (coeffValid),
    .coeffSetFlag   (coeffSetFlag),
    .busy           (busy),
    .error          (error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int bank, input int addr, input int data);
    wrEnable = 1'b1;
    wrBank   = 2'(bank);
    wrAddr   = 5'(addr);
    wrData   = 18'(data);
    tick();
    wrEnable = 1'b0;
  endtask

  // Stream one bank for a fixed window, capturing valid taps and the cycle
  // (counted from the first edge after enable) where each event happened.
  task automatic run_stream(input int bank, output int n_valid, output int first_cyc,
                            output int last_cyc, output int flag_cyc,
                            output bit flag_end, output int got[27]);
    bankSelect = 2'(bank);
    enable = 1'b1;
    n_valid = 0; first_cyc = -1; last_cyc = -1; flag_cyc = -1;
    for (int k = 0; k < 27; k++) got[k] = 99999;
    for (int c = 0; c < 34; c++) begin
      tick();
      if (coeffValid) begin
        if (n_valid < 27) got[n_valid] = int'(coefficientOut);
        n_valid++;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
      if (coeffSetFlag && flag_cyc < 0) flag_cyc = c;
    end
    flag_end = coeffSetFlag;
    enable = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (coeffValid !== 1'b0 || busy !== 1'b0 || coeffSetFlag !== 1'b0 || error !== 1'b0)
      begin n_fail++; $display("FAIL reset_ctrl: valid=%b busy=%b flag=%b err=%b, required 0000",
                               coeffValid, busy, coeffSetFlag, error); end
    n_checks++;
    if (coefficientOut !== 18'sd0)
      begin n_fail++; $display("FAIL reset_out: got %0d required 0", coefficientOut); end
  endtask

`ifndef SETUP_COEFF_FOLD_EN
  task automatic test_hilbert();
    int nv, fc, lc, flc, got[27], bad;
    bit fe;
    for (int k = 0; k < 27; k++) wr(0, k, hil[k]);
    run_stream(0, nv, fc, lc, flc, fe, got);
    n_checks++;
    if (nv !== 27 || fc !== 0 || lc !== 26)
      begin n_fail++; $display("FAIL hil_window: valid=%0d first=%0d last=%0d required 27/0/26", nv, fc, lc); end
    n_checks++;
    if (flc !== 26 || fe !== 1'b1)
      begin n_fail++; $display("FAIL hil_flag: rise=%0d held=%b required 26/1", flc, fe); end
    n_checks++;
    if (got[0] !== -775 || got[26] !== 775)
      begin n_fail++; $display("FAIL hil_ends: first=%0d last=%0d required -775/775", got[0], got[26]); end
    bad = 0;
    for (int k = 0; k < 27; k++) if (got[k] !== hil[k]) bad++;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL hil_taps: %0d wrong taps, required 0", bad); end
    n_checks++;
    if (coeffSetFlag !== 1'b0 || coeffValid !== 1'b0)
      begin n_fail++; $display("FAIL hil_drop: flag=%b valid=%b required 0/0", coeffSetFlag, coeffValid); end
  endtask

  task automatic test_bank_select_toggle();
    int bad = 0;
    for (int k = 0; k < 27; k++) wr(2, k, k + 1);
    bankSelect = 2'd2;
    enable = 1'b1;
    for (int i = 0; i < 27; i++) begin
      tick();
      if (i == 0) bankSelect = 2'd0;
      if (i == 13) bankSelect = 2'd1;
      if (coeffValid !== 1'b1 || coefficientOut !== 18'(i + 1)) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL sel_toggle: %0d wrong taps, required 0", bad); end
    tick();
    n_checks++;
    if (coeffSetFlag !== 1'b1 || coeffValid !== 1'b0 || busy !== 1'b0 || coefficientOut !== 18'sd0)
      begin n_fail++; $display("FAIL done_state: flag=%b valid=%b busy=%b out=%0d required 1/0/0/0",
                               coeffSetFlag, coeffValid, busy, coefficientOut); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    bit flag_seen = 1'b0;
    bankSelect = 2'd0;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    enable = 1'b0;
    tick();
    n_checks++;
    if (coeffValid !== 1'b0 || coefficientOut !== 18'sd0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL abort_out: valid=%b out=%0d busy=%b required 0/0/0",
                               coeffValid, coefficientOut, busy); end
    for (int i = 0; i < 20; i++) begin
      if (coeffSetFlag) flag_seen = 1'b1;
      tick();
    end
    n_checks++;
    if (flag_seen !== 1'b0) begin n_fail++; $display("FAIL abort_flag: flag rose %b, required 0", flag_seen); end
    enable = 1'b1;
    tick();
    n_checks++;
    if (coeffValid !== 1'b1 || coefficientOut !== -18'sd775)
      begin n_fail++; $display("FAIL abort_restart: valid=%b out=%0d required 1/-775", coeffValid, coefficientOut); end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_writes_during_stream();
    int nv, fc, lc, flc, got[27];
    bit fe;
    for (int k = 0; k < 27; k++) wr(1, k, 100 + k);
    for (int k = 0; k < 27; k++) wr(3, k, 300 + k);
    bankSelect = 2'd1;
    enable = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_on: got %b required 1", busy); end
    wr(1, 3, 999);
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL wr_active_bank: error=%b required 1", error); end
    wr(3, 5, -42);
    n_checks++;
    if (error !== 1'b0) begin n_fail++; $display("FAIL wr_other_bank: error=%b required 0", error); end
    wr(0, 27, 7);
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL wr_bad_addr: error=%b required 1", error); end
    tick();
    n_checks++;
    if (error !== 1'b0 || coefficientOut !== 18'sd104)
      begin n_fail++; $display("FAIL err_pulse: error=%b out=%0d required 0/104", error, coefficientOut); end
    enable = 1'b0;
    tick();
    run_stream(1, nv, fc, lc, flc, fe, got);
    n_checks++;
    if (got[3] !== 103 || got[5] !== 105 || nv !== 27)
      begin n_fail++; $display("FAIL bank1_kept: tap3=%0d tap5=%0d n=%0d required 103/105/27", got[3], got[5], nv); end
    run_stream(3, nv, fc, lc, flc, fe, got);
    n_checks++;
    if (got[5] !== -42 || got[4] !== 304)
      begin n_fail++; $display("FAIL bank3_write: tap5=%0d tap4=%0d required -42/304", got[5], got[4]); end
    run_stream(0, nv, fc, lc, flc, fe, got);
    n_checks++;
    if (got[26] !== 775 || nv !== 27)
      begin n_fail++; $display("FAIL bank0_untouched: tap26=%0d n=%0d required 775/27", got[26], nv); end
  endtask

  task automatic test_reset_mid_stream();
    int nv, fc, lc, flc, got[27], bad;
    bit fe;
    bankSelect = 2'd0;
    enable = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    n_checks++;
    if (coefficientOut !== 18'sd0 || coeffValid !== 1'b1)
      begin n_fail++; $display("FAIL tap13: out=%0d valid=%b required 0/1", coefficientOut, coeffValid); end
    reset = 1'b1;
    tick();
    n_checks++;
    if (coeffValid !== 1'b0 || busy !== 1'b0 || coeffSetFlag !== 1'b0 || coefficientOut !== 18'sd0)
      begin n_fail++; $display("FAIL reset_mid: valid=%b busy=%b flag=%b out=%0d required 0/0/0/0",
                               coeffValid, busy, coeffSetFlag, coefficientOut); end
    reset = 1'b0;
    enable = 1'b0;
    tick();
    run_stream(0, nv, fc, lc, flc, fe, got);
    bad = 0;
    for (int k = 0; k < 27; k++) if (got[k] !== hil[k]) bad++;
    n_checks++;
    if (bad !== 0 || nv !== 27 || fc !== 0)
      begin n_fail++; $display("FAIL mem_retained: wrong=%0d n=%0d first=%0d required 0/27/0", bad, nv, fc); end
  endtask
`else
  task automatic test_fold();
    int nv, fc, lc, flc, got[27], bad;
    bit fe;
    for (int k = 0; k < 14; k++) wr(0, k, hil[k]);
    wr(0, 14, 5);
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL fold_wr_high: error=%b required 1", error); end
    run_stream(0, nv, fc, lc, flc, fe, got);
    bad = 0;
    for (int k = 0; k < 27; k++) if (got[k] !== hil[k]) bad++;
    n_checks++;
    if (bad !== 0 || nv !== 27 || flc !== 26)
      begin n_fail++; $display("FAIL fold_hil: wrong=%0d n=%0d flag=%0d required 0/27/26", bad, nv, flc); end
    wr(0, 0, -131072);
    run_stream(0, nv, fc, lc, flc, fe, got);
    n_checks++;
    if (got[0] !== -131072 || got[26] !== 131071)
      begin n_fail++; $display("FAIL fold_sat: tap0=%0d tap26=%0d required -131072/131071", got[0], got[26]); end
    wr(1, 0, 500);
    run_stream(1, nv, fc, lc, flc, fe, got);
    n_checks++;
    if (got[0] !== 500 || got[26] !== 500)
      begin n_fail++; $display("FAIL fold_sym: tap0=%0d tap26=%0d required 500/500", got[0], got[26]); end
  endtask
`endif

  initial begin
    tick();
    test_reset();
`ifdef SETUP_COEFF_FOLD_EN
    test_fold();
`else
    test_hilbert();
    test_bank_select_toggle();
    test_abort();
    test_writes_during_stream();
    test_reset_mid_stream();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
